// File: rtl/regfile_sb.sv
// regfile_sb: parametrised two-read/one-write register file with optional
// same-cycle write-to-read bypass, a per-register pending scoreboard for
// multi-cycle producers, and a sequenced clear engine that zeroes one entry
// per cycle.
module regfile_sb #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_reg,
  input  logic [AW-1:0]    DR,
  input  logic [WIDTH-1:0] Load_data,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  output logic [WIDTH-1:0] SR1_out,
  output logic [WIDTH-1:0] SR2_out,
  output logic             SR1_ready,
  output logic             SR2_ready,
  input  logic             Claim,
  input  logic [AW-1:0]    Claim_DR,
  input  logic             Clr_req,
  output logic             Busy
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t           state;
  logic [AW-1:0]    clr_cnt;
  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] pending;
  logic             idle;
  logic             byp1;
  logic             byp2;

  assign idle = (state == ST_IDLE);

  // Clear sequencer: walks clr_cnt from 0 to NREGS-1 once per request, Busy registered with the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      Busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Clr_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            Busy    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == LAST_IDX) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
            Busy    <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register and scoreboard update; the claim is applied after the write so a new producer keeps the entry pending.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pending <= '0;
    end else if (!idle) begin
      regs[clr_cnt]    <= '0;
      pending[clr_cnt] <= 1'b0;
    end else begin
      if (LD_reg) begin
        regs[DR]    <= Load_data;
        pending[DR] <= 1'b0;
      end
      if (Claim) pending[Claim_DR] <= 1'b1;
    end
  end

  // Combinational read ports with optional forwarding of the in-flight write (suppressed while clearing).
  always_comb begin
    byp1      = (BYPASS != 0) && idle && LD_reg && (DR == SR1);
    byp2      = (BYPASS != 0) && idle && LD_reg && (DR == SR2);
    SR1_out   = byp1 ? Load_data : regs[SR1];
    SR2_out   = byp2 ? Load_data : regs[SR2];
    SR1_ready = (byp1 && !(Claim && (Claim_DR == SR1))) ? 1'b1 : ~pending[SR1];
    SR2_ready = (byp2 && !(Claim && (Claim_DR == SR2))) ? 1'b1 : ~pending[SR2];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic for regfile_sb,
// checked against a behavioural register-file model held in the bench.
module tb_regfile_sb;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  // shared stimulus for the 16x8 bypass and non-bypass instances
  logic        Reset, LD_reg, Claim, Clr_req;
  logic [2:0]  DR, SR1, SR2, Claim_DR;
  logic [15:0] Load_data;
  logic [15:0] SR1_out, SR2_out, nb_SR1_out, nb_SR2_out;
  logic        SR1_ready, SR2_ready, Busy, nb_SR1_ready, nb_SR2_ready, nb_Busy;

  // 32x16 instance
  logic        w_Reset, w_LD_reg, w_Claim, w_Clr_req;
  logic [3:0]  w_DR, w_SR1, w_SR2, w_Claim_DR;
  logic [31:0] w_Load_data, w_SR1_out, w_SR2_out;
  logic        w_SR1_ready, w_SR2_ready, w_Busy;

  int vectors = 0;
  int miscompares = 0;

  regfile_sb #(.WIDTH(16), .NREGS(8), .BYPASS(1)) dut (
    .Clk(Clk), .Reset(Reset), .LD_reg(LD_reg), .DR(DR), .Load_data(Load_data),
    .SR1(SR1), .SR2(SR2), .SR1_out(SR1_out), .SR2_out(SR2_out),
    .SR1_ready(SR1_ready), .SR2_ready(SR2_ready), .Claim(Claim),
    .Claim_DR(Claim_DR), .Clr_req(Clr_req), .Busy(Busy));

  regfile_sb #(.WIDTH(16), .NREGS(8), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Reset(Reset), .LD_reg(LD_reg), .DR(DR), .Load_data(Load_data),
    .SR1(SR1), .SR2(SR2), .SR1_out(nb_SR1_out), .SR2_out(nb_SR2_out),
    .SR1_ready(nb_SR1_ready), .SR2_ready(nb_SR2_ready), .Claim(Claim),
    .Claim_DR(Claim_DR), .Clr_req(Clr_req), .Busy(nb_Busy));

  regfile_sb #(.WIDTH(32), .NREGS(16), .BYPASS(1)) dut_w (
    .Clk(Clk), .Reset(w_Reset), .LD_reg(w_LD_reg), .DR(w_DR), .Load_data(w_Load_data),
    .SR1(w_SR1), .SR2(w_SR2), .SR1_out(w_SR1_out), .SR2_out(w_SR2_out),
    .SR1_ready(w_SR1_ready), .SR2_ready(w_SR2_ready), .Claim(w_Claim),
    .Claim_DR(w_Claim_DR), .Clr_req(w_Clr_req), .Busy(w_Busy));

  // ---------------- behavioural model of the 16x8 file ----------------
  logic [15:0] m_r [8];
  bit          m_p [8];
  bit          m_busy;
  int          m_idx;

  task automatic m_step();
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin m_r[i] = 16'h0; m_p[i] = 1'b0; end
      m_busy = 1'b0;
      m_idx  = 0;
    end else if (m_busy) begin
      m_r[m_idx] = 16'h0;
      m_p[m_idx] = 1'b0;
      m_idx++;
      if (m_idx == 8) m_busy = 1'b0;
    end else begin
      if (LD_reg) begin m_r[DR] = Load_data; m_p[DR] = 1'b0; end
      if (Claim) m_p[Claim_DR] = 1'b1;
      if (Clr_req) begin m_busy = 1'b1; m_idx = 0; end
    end
  endtask

  function automatic logic [15:0] exp_out(input logic [2:0] sr, input bit byp);
    if (byp && !m_busy && LD_reg && DR == sr) return Load_data;
    return m_r[sr];
  endfunction

  function automatic logic exp_rdy(input logic [2:0] sr, input bit byp);
    if (byp && !m_busy && LD_reg && DR == sr && !(Claim && Claim_DR == sr)) return 1'b1;
    return !m_p[sr];
  endfunction

  task automatic tick();
    @(posedge Clk);
    m_step();
    #1;
  endtask

  task automatic idle_in();
    LD_reg = 0; Claim = 0; Clr_req = 0; DR = 0; Claim_DR = 0; Load_data = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1; idle_in(); SR1 = 0; SR2 = 5;
    tick(); tick();
    Reset = 0;
    @(negedge Clk);
    vectors++; if (SR1_out !== 16'h0) begin miscompares++; $display("FAIL reset_sr1_out: got %h want 0000", SR1_out); end
    vectors++; if (SR2_out !== 16'h0) begin miscompares++; $display("FAIL reset_sr2_out: got %h want 0000", SR2_out); end
    vectors++; if (SR1_ready !== 1'b1 || SR2_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b%b want 11", SR1_ready, SR2_ready); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", Busy); end
    tick();
  endtask

  task automatic test_write_read();
    LD_reg = 1; DR = 3; Load_data = 16'hBEEF;
    tick();
    idle_in(); SR1 = 3; SR2 = 0;
    @(negedge Clk);
    vectors++; if (SR1_out !== 16'hBEEF) begin miscompares++; $display("FAIL wr_sr1_out: got %h want beef", SR1_out); end
    vectors++; if (SR2_out !== 16'h0000) begin miscompares++; $display("FAIL wr_sr2_out: got %h want 0000", SR2_out); end
    vectors++; if (SR1_ready !== 1'b1 || SR2_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready: got %b%b want 11", SR1_ready, SR2_ready); end
    tick();
  endtask

  task automatic test_bypass();
    LD_reg = 1; DR = 5; Load_data = 16'h1111;
    tick();
    Load_data = 16'h2222; SR1 = 5;
    @(negedge Clk);
    vectors++; if (SR1_out !== 16'h2222) begin miscompares++; $display("FAIL byp_same_cycle: got %h want 2222", SR1_out); end
    vectors++; if (nb_SR1_out !== 16'h1111) begin miscompares++; $display("FAIL nobyp_same_cycle: got %h want 1111", nb_SR1_out); end
    tick();
    idle_in();
    @(negedge Clk);
    vectors++; if (nb_SR1_out !== 16'h2222) begin miscompares++; $display("FAIL nobyp_next_cycle: got %h want 2222", nb_SR1_out); end
    tick();
  endtask

  task automatic test_scoreboard();
    Claim = 1; Claim_DR = 2; SR2 = 2;
    @(negedge Clk);
    vectors++; if (SR2_ready !== 1'b1) begin miscompares++; $display("FAIL claim_same_cycle_ready: got %b want 1", SR2_ready); end
    tick();
    idle_in(); LD_reg = 1; DR = 2; Load_data = 16'h00AA;
    @(negedge Clk);
    vectors++; if (nb_SR2_ready !== 1'b0) begin miscompares++; $display("FAIL claim_pending: got %b want 0", nb_SR2_ready); end
    vectors++; if (SR2_ready !== 1'b1 || SR2_out !== 16'h00AA) begin miscompares++; $display("FAIL byp_ready: got %b/%h want 1/00aa", SR2_ready, SR2_out); end
    tick();
    idle_in();
    @(negedge Clk);
    vectors++; if (SR2_ready !== 1'b1 || nb_SR2_ready !== 1'b1) begin miscompares++; $display("FAIL write_clears_pending: got %b%b want 11", SR2_ready, nb_SR2_ready); end
    LD_reg = 1; DR = 2; Load_data = 16'h00AA; Claim = 1; Claim_DR = 2;
    tick();
    idle_in();
    @(negedge Clk);
    vectors++; if (SR2_out !== 16'h00AA || SR2_ready !== 1'b0) begin miscompares++; $display("FAIL claim_write_same_reg: got %h/%b want 00aa/0", SR2_out, SR2_ready); end
    LD_reg = 1; DR = 1; Load_data = 16'h1234; Claim = 1; Claim_DR = 4;
    tick();
    idle_in(); SR1 = 1; SR2 = 4;
    @(negedge Clk);
    vectors++; if (SR1_out !== 16'h1234 || SR1_ready !== 1'b1) begin miscompares++; $display("FAIL write_diff_reg: got %h/%b want 1234/1", SR1_out, SR1_ready); end
    vectors++; if (SR2_ready !== 1'b0) begin miscompares++; $display("FAIL claim_diff_reg: got %b want 0", SR2_ready); end
    tick();
  endtask

  task automatic test_clear();
    int busy_cycles;
    for (int i = 0; i < 8; i++) begin
      LD_reg = 1; DR = 3'(i); Load_data = 16'(16'h0101 * i);
      tick();
    end
    idle_in(); Clr_req = 1;
    tick();
    Clr_req = 0;
    busy_cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      LD_reg = (k == 3); DR = 7; Load_data = 16'hFFFF; SR1 = 7; SR2 = 0;
      @(negedge Clk);
      if (!Busy) break;
      busy_cycles++;
      vectors++; if (SR1_out !== 16'h0707) begin miscompares++; $display("FAIL clr_r7_hold cyc %0d: got %h want 0707", k, SR1_out); end
      if (k >= 2) begin
        vectors++; if (SR2_out !== 16'h0) begin miscompares++; $display("FAIL clr_r0_cleared cyc %0d: got %h want 0000", k, SR2_out); end
      end
      tick();
    end
    vectors++; if (busy_cycles != 8) begin miscompares++; $display("FAIL clr_busy_len: got %0d want 8", busy_cycles); end
    // a request in the first idle cycle starts another clear
    idle_in(); Clr_req = 1;
    tick();
    Clr_req = 0;
    @(negedge Clk);
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL clr_back_to_back: got %b want 1", Busy); end
    for (int k = 0; k < 20 && Busy; k++) begin tick(); @(negedge Clk); end
    tick();
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(7 - i);
      @(negedge Clk);
      vectors++; if (SR1_out !== 16'h0 || nb_SR2_out !== 16'h0) begin miscompares++; $display("FAIL clr_all_zero r%0d: got %h/%h want 0000", i, SR1_out, nb_SR2_out); end
      tick();
    end
  endtask

  task automatic test_reset_midclear();
    idle_in(); LD_reg = 1; DR = 6; Load_data = 16'h6666; Claim = 1; Claim_DR = 6;
    tick();
    idle_in(); Clr_req = 1;
    tick();
    Clr_req = 0;
    tick(); tick(); tick();
    Reset = 1; SR1 = 6;
    @(negedge Clk);
    vectors++; if (Busy !== 1'b1 || SR1_ready !== 1'b0 || SR1_out !== 16'h6666) begin miscompares++; $display("FAIL midclr_before: got %b/%b/%h want 1/0/6666", Busy, SR1_ready, SR1_out); end
    tick();
    Reset = 0;
    @(negedge Clk);
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL midclr_busy: got %b want 0", Busy); end
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(i);
      @(negedge Clk);
      vectors++; if (SR1_out !== 16'h0 || SR1_ready !== 1'b1 || SR2_ready !== 1'b1) begin miscompares++; $display("FAIL midclr_r%0d: got %h/%b%b want 0000/11", i, SR1_out, SR1_ready, SR2_ready); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      Reset     = ($urandom_range(63) == 0);
      LD_reg    = 1'($urandom_range(1));
      DR        = 3'($urandom);
      Load_data = 16'($urandom);
      SR1       = ($urandom_range(2) == 0) ? DR : 3'($urandom);
      SR2       = ($urandom_range(3) == 0) ? SR1 : 3'($urandom);
      Claim     = ($urandom_range(2) == 0);
      Claim_DR  = ($urandom_range(3) == 0) ? DR : 3'($urandom);
      Clr_req   = ($urandom_range(15) == 0);
      @(negedge Clk);
      vectors++; if (SR1_out !== exp_out(SR1, 1)) begin miscompares++; $display("FAIL rnd_sr1_out n%0d: got %h want %h", n, SR1_out, exp_out(SR1, 1)); end
      vectors++; if (SR2_out !== exp_out(SR2, 1)) begin miscompares++; $display("FAIL rnd_sr2_out n%0d: got %h want %h", n, SR2_out, exp_out(SR2, 1)); end
      vectors++; if (SR1_ready !== exp_rdy(SR1, 1)) begin miscompares++; $display("FAIL rnd_sr1_ready n%0d: got %b want %b", n, SR1_ready, exp_rdy(SR1, 1)); end
      vectors++; if (SR2_ready !== exp_rdy(SR2, 1)) begin miscompares++; $display("FAIL rnd_sr2_ready n%0d: got %b want %b", n, SR2_ready, exp_rdy(SR2, 1)); end
      vectors++; if (Busy !== m_busy) begin miscompares++; $display("FAIL rnd_busy n%0d: got %b want %b", n, Busy, m_busy); end
      vectors++; if (nb_SR1_out !== exp_out(SR1, 0)) begin miscompares++; $display("FAIL rnd_nb_sr1_out n%0d: got %h want %h", n, nb_SR1_out, exp_out(SR1, 0)); end
      vectors++; if (nb_SR2_out !== exp_out(SR2, 0)) begin miscompares++; $display("FAIL rnd_nb_sr2_out n%0d: got %h want %h", n, nb_SR2_out, exp_out(SR2, 0)); end
      vectors++; if (nb_SR1_ready !== exp_rdy(SR1, 0)) begin miscompares++; $display("FAIL rnd_nb_sr1_ready n%0d: got %b want %b", n, nb_SR1_ready, exp_rdy(SR1, 0)); end
      vectors++; if (nb_SR2_ready !== exp_rdy(SR2, 0)) begin miscompares++; $display("FAIL rnd_nb_sr2_ready n%0d: got %b want %b", n, nb_SR2_ready, exp_rdy(SR2, 0)); end
      vectors++; if (nb_Busy !== m_busy) begin miscompares++; $display("FAIL rnd_nb_busy n%0d: got %b want %b", n, nb_Busy, m_busy); end
      tick();
    end
    Reset = 0; idle_in();
  endtask

  task automatic test_wide();
    int busy_cycles;
    w_Reset = 1;
    tick();
    w_Reset = 0; w_LD_reg = 1; w_DR = 15; w_Load_data = 32'hDEADBEEF;
    tick();
    w_LD_reg = 0; w_SR1 = 15; w_SR2 = 14;
    @(negedge Clk);
    vectors++; if (w_SR1_out !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wide_r15: got %h want deadbeef", w_SR1_out); end
    vectors++; if (w_SR2_out !== 32'h0 || w_SR1_ready !== 1'b1) begin miscompares++; $display("FAIL wide_r14: got %h/%b want 00000000/1", w_SR2_out, w_SR1_ready); end
    w_Clr_req = 1;
    tick();
    w_Clr_req = 0;
    busy_cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (!w_Busy) break;
      busy_cycles++;
      vectors++; if (w_SR1_out !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wide_clr_r15_hold cyc %0d: got %h want deadbeef", k, w_SR1_out); end
      tick();
    end
    vectors++; if (busy_cycles != 16) begin miscompares++; $display("FAIL wide_clr_len: got %0d want 16", busy_cycles); end
    vectors++; if (w_SR1_out !== 32'h0) begin miscompares++; $display("FAIL wide_clr_done: got %h want 00000000", w_SR1_out); end
  endtask

  initial begin
    Reset = 1; idle_in(); SR1 = 0; SR2 = 0;
    w_Reset = 1; w_LD_reg = 0; w_Claim = 0; w_Clr_req = 0;
    w_DR = 0; w_Claim_DR = 0; w_Load_data = 0; w_SR1 = 0; w_SR2 = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_reset_midclear();
    test_random();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the datapath, generalising the fixed 8×16 two-read/one-write file. It adds configurable width and depth, optional same-cycle write-to-read bypass, a per-register pending scoreboard for multi-cycle producers, and a sequenced clear engine. It sits between the bus/ALU result path (write side) and the ALU/address operand muxes (read side).

## Interface
Parameters:
- WIDTH, 16, data width of each register
- NREGS, 8, register count; power of two, ≥2
- AW, $clog2(NREGS), derived address width; not overridden
- BYPASS, 1, 1 = write data forwarded to same-cycle reads of the written register

Ports:
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high
- LD_reg  in  1  write enable
- DR  in  AW  write address
- Load_data  in  WIDTH  write data
- SR1, SR2  in  AW  read addresses
- SR1_out, SR2_out  out  WIDTH  read data
- SR1_ready, SR2_ready  out  1  addressed register not pending
- Claim  in  1  mark register Claim_DR pending
- Claim_DR  in  AW  register to claim
- Clr_req  in  1  start sequenced clear of all registers
- Busy  out  1  clear engine active

## Operation
- Storage: NREGS×WIDTH registers plus an NREGS-bit pending vector.
- Reset (sync): all registers 0, pending all 0, FSM → IDLE, clear counter 0.
- FSM states: IDLE, CLEAR.
  - IDLE → CLEAR when Clr_req=1; counter loads 0.
  - In CLEAR, each cycle: R[counter] ← 0, pending[counter] ← 0, counter increments.
  - CLEAR → IDLE on the cycle counter = NREGS−1 is written. There is no wrap-around.
  - Clr_req while in CLEAR is ignored.
- Busy = 1 exactly while the FSM is in CLEAR.
- Write: in IDLE, when LD_reg=1, R[DR] ← Load_data and pending[DR] ← 0. In CLEAR, LD_reg is ignored.
- Claim: in IDLE, when Claim=1, pending[Claim_DR] ← 1. In CLEAR, Claim is ignored.
- Claim and LD_reg on the same register in the same cycle: data is written and pending ends at 1 (the new producer wins).
- Claim and LD_reg on different registers: both take effect.
- Clr_req, LD_reg and Claim in the same IDLE cycle: the write and claim take effect this cycle; CLEAR starts next cycle and overwrites them in sequence.
- Read (combinational): SRx_out = R[SRx].
  - If BYPASS=1, FSM is IDLE, LD_reg=1 and DR=SRx: SRx_out = Load_data.
  - SR1 = SR2 is legal; both ports return identical data.
- Ready: SRx_ready = ~pending[SRx].
  - If BYPASS=1, the same-cycle bypass condition also forces SRx_ready=1, unless Claim with Claim_DR=SRx is in the same cycle.
- During CLEAR, reads return current stored contents with no bypass. Already-cleared entries read 0.
- Out-of-range addresses cannot occur because NREGS is a power of two.

## Timing
- Read latency 0: combinational from SRx, R and the bypass inputs.
- Write and claim take effect at posedge; visible on reads the following cycle, or the same cycle via bypass.
- Clear takes NREGS cycles after the posedge that samples Clr_req. Busy rises on that edge and falls after NREGS cycles.
  - Back-to-back: a Clr_req sampled on the cycle Busy falls starts a new clear.
- Reset mid-clear: the FSM returns to IDLE immediately and all state is zeroed on that edge.
- Reset values: SRx_out = 0 for any address, SRx_ready = 1, Busy = 0.

## Test plan
- Reset, then write R3 ← 16'hBEEF. Read SR1=3, SR2=0 next cycle → SR1_out=BEEF, SR2_out=0000, both ready=1.
- BYPASS=1, R5=0x1111: write R5 ← 0x2222 with SR1=5 in the same cycle → SR1_out=2222 that cycle; without bypass (BYPASS=0) SR1_out=1111 that cycle and 2222 next cycle.
- Claim R2 → SR2_ready=0 from the next cycle. Write R2 ← 0x00AA → ready=1 next cycle. Claim and write R2 in the same cycle → data=00AA, ready=0.
- Fill R0–R7 with 0x0101·i, then pulse Clr_req:
  - Busy=1 for exactly 8 cycles.
  - LD_reg to R7 in cycle 3 of the clear is ignored.
  - All reads are 0 after Busy falls.
  - R7 reads 0x0707 until cycle 8 of the clear.
- Assert Reset in cycle 4 of a clear, with pending R6 set → Busy=0 next cycle, all regs 0, all ready=1.
- WIDTH=32, NREGS=16: write R15 ← 32'hDEADBEEF → read back exactly. Clear takes 16 cycles.
